// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder controller.
//   - state_t       : controller FSM states (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand/result width in bits
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// full_adder
//   Single-bit full adder, the only arithmetic element of the serial adder.
//   Ports:
//     a, b  : input addend bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder: one full adder is sequenced LSB first, one bit per
//   clock, over WIDTH cycles. Valid/ready handshake on both sides, no
//   overlap of operations.
//   Optional feature: define SERIAL_ADD_SUB_EN to add the Sub input
//   (A - B, Cout=1 means no borrow).
//   Ports:
//     Clk, Rst_N          : clock, asynchronous active-low reset
//     In_Valid / In_Ready : operand handshake (A, B, Cin [, Sub])
//     A, B, Cin           : operands and carry in
//     Out_Valid/Out_Ready : result handshake (Sum, Cout)
//     Sum, Cout           : result (partial values while running)
//     Busy                : high whenever the FSM is not IDLE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_b;
  logic fa_s;
  logic fa_co;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  // Subtraction is A + ~B + 1: invert B into the adder, start carry at 1.
  assign fa_b = b_q[0] ^ sub_q;
`else
  assign fa_b = b_q[0];
`endif

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (fa_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d     = sub_q;
`endif
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b1;

    case (state_q)
      IDLE: begin
        In_Ready = 1'b1;
        Busy     = 1'b0;
        if (In_Valid) begin
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = Sub;
          carry_d = Sub ? 1'b1 : Cin;
`else
          carry_d = Cin;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum fills from the MSB end; after WIDTH shifts bit 0 of the
        // result has reached Sum[0].
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Sum  = sum_q;
  // The carry register holds the carry out of the last processed bit.
  assign Cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors,
//   back-pressure, ignored In_Valid while running, mid-operation reset and
//   random operands against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         Clk;
  logic         Rst_N;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         Sub;
`endif
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst_N     (Rst_N),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef SERIAL_ADD_SUB_EN
    .Sub       (Sub),
`endif
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result is {Cout, Sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // One full transaction. Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W:0] exp,
                        input int unsigned hold, input bit noise);
    int unsigned lat;
    logic [W-1:0] held_sum;
    logic         held_cout;
    check({tag, " in_ready_idle"}, 64'(In_Ready), 64'd1);
    In_Valid = 1'b1;
    A = a;
    B = b;
    Cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    Sub = sub;
`endif
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    check({tag, " busy_run"}, 64'(Busy), 64'd1);
    check({tag, " in_ready_run"}, 64'(In_Ready), 64'd0);
    lat = 0;
    for (int unsigned n = 1; n <= W + 6; n++) begin
      if (noise) begin
        In_Valid = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
        Cin = 1'($urandom);
      end
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      if (Out_Valid) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(W));
    check({tag, " sum"}, 64'(Sum), 64'(exp[W-1:0]));
    check({tag, " cout"}, 64'(Cout), 64'(exp[W]));
    held_sum  = Sum;
    held_cout = Cout;
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge Clk);
      #1;
      check({tag, " hold_valid"}, 64'(Out_Valid), 64'd1);
      check({tag, " hold_in_ready"}, 64'(In_Ready), 64'd0);
      check({tag, " hold_result"}, {55'd0, held_cout, held_sum}, {55'd0, Cout, Sum});
    end
    Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    Out_Ready = 1'b0;
    check({tag, " release_valid"}, 64'(Out_Valid), 64'd0);
    check({tag, " release_in_ready"}, 64'(In_Ready), 64'd1);
    check({tag, " release_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    bit           seen_valid;

    Rst_N = 1'b0;
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    A = '0;
    B = '0;
    Cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    Sub = 1'b0;
`endif
    #22;
    check("rst out_valid", 64'(Out_Valid), 64'd0);
    check("rst busy", 64'(Busy), 64'd0);
    check("rst sum", 64'(Sum), 64'd0);
    check("rst cout", 64'(Cout), 64'd0);
    check("rst in_ready", 64'(In_Ready), 64'd1);
    Rst_N = 1'b1;
    @(posedge Clk);
    #1;

    run_op("5a+33", 8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D, 0, 1'b0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0, 1'b0);
    run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0, 1'b0);
    run_op("backpressure", 8'h3C, 8'hC4, 1'b1, 1'b0, 9'h101, 5, 1'b0);
    run_op("noise", 8'h12, 8'h34, 1'b1, 1'b0, 9'h047, 1, 1'b1);

    // Reset in the middle of an operation: outputs clear without a clock
    // edge and the aborted operation never produces a result.
    In_Valid = 1'b1;
    A = 8'hAA;
    B = 8'h77;
    Cin = 1'b1;
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst_N = 1'b0;
    #1;
    check("midrst out_valid", 64'(Out_Valid), 64'd0);
    check("midrst busy", 64'(Busy), 64'd0);
    check("midrst sum", 64'(Sum), 64'd0);
    check("midrst cout", 64'(Cout), 64'd0);
    check("midrst in_ready", 64'(In_Ready), 64'd1);
    #2;
    Rst_N = 1'b1;
    seen_valid = 1'b0;
    for (int unsigned n = 0; n < W + 4; n++) begin
      @(posedge Clk);
      #1;
      if (Out_Valid) seen_valid = 1'b1;
    end
    check("midrst no_result", 64'(seen_valid), 64'd0);
    run_op("post_rst 01+01", 8'h01, 8'h01, 1'b0, 1'b0, 9'h002, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub 10-01", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0, 1'b0);
    run_op("sub 01-02", 8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, 0, 1'b0);
`endif

    for (int unsigned i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op("random", ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0),
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits, legal range 2..64.
REQ-002 SHALL have port: Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: Rst_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: In_Valid  input  1  operands and Cin valid.
REQ-005 SHALL have port: In_Ready  output  1  block accepts operands.
REQ-006 SHALL have ports: A  input  WIDTH and B  input  WIDTH, the operands.
REQ-007 SHALL have port: Cin  input  1  carry-in.
REQ-008 SHALL have port: Out_Valid  output  1  result valid.
REQ-009 SHALL have port: Out_Ready  input  1  consumer takes result.
REQ-010 SHALL have ports: Sum  output  WIDTH and Cout  output  1, the result.
REQ-011 SHALL have port: Busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL sequence one 1-bit full adder bit-serially, LSB first, one bit per Clk cycle.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE: SHALL drive In_Ready=1 and Out_Valid=0; on In_Valid&In_Ready it SHALL load the A/B shift registers, set carry register=Cin, clear the bit counter and go to RUN.
REQ-015 In RUN: each cycle SHALL add the LSBs of A/B with the carry register, shift the sum bit into Sum MSB (Sum shifts right), update the carry register and increment the counter.
REQ-016 In RUN at counter==WIDTH-1: SHALL go to DONE after that bit is added; RUN SHALL last exactly WIDTH cycles.
REQ-017 Out_Valid SHALL rise exactly WIDTH rising edges after the accepting edge.
REQ-018 In DONE: SHALL drive Out_Valid=1, In_Ready=0, and hold Sum/Cout stable until Out_Valid&Out_Ready, then go to IDLE.
REQ-019 In_Ready SHALL be 0 in RUN and DONE; In_Valid there SHALL be ignored, with no pipelining of back-to-back operations.
REQ-020 Sum/Cout SHALL be meaningful only while Out_Valid=1; during RUN they SHALL expose partial values.
REQ-021 Cout SHALL equal the carry out of bit WIDTH-1, with no wrap into Sum.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide.

Reset
REQ-023 Rst_N low SHALL immediately force state=IDLE and clear Sum, Cout, the carry register, the counter and the shift registers.
REQ-024 While Rst_N is low: Out_Valid=0, Busy=0, Sum=0, Cout=0, In_Ready=1 (IDLE decode).
REQ-025 An operation in progress when Rst_N asserts SHALL be discarded, with no Out_Valid for it.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN defined: SHALL add input Sub (1 bit), captured with the operands; when Sub=1, B bits SHALL be inverted into the adder, the initial carry SHALL be 1 and Cin SHALL be ignored; Cout=1 means no borrow.
REQ-027 Macro SERIAL_ADD_SUB_EN undefined: the Sub port SHALL be absent and the block SHALL perform add only.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state enum typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 SHALL instantiate the existing full_adder sub-module exactly once as the only arithmetic element, with no behavioural "+".

Verification (WIDTH=8)
REQ-030 A=0x5A, B=0x33, Cin=0 -> Sum=0x8D, Cout=0, Out_Valid exactly 8 edges after accept.
REQ-031 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
REQ-032 Out_Ready held 0 for 5 cycles in DONE -> Out_Valid=1 and Sum/Cout stable with In_Ready=0; release -> IDLE and In_Ready=1 next cycle.
REQ-033 In_Valid toggled during RUN with different operands -> ignored; result matches originally accepted operands.
REQ-034 Rst_N pulsed low after 3 RUN cycles -> outputs cleared asynchronously, no Out_Valid; next op A=0x01, B=0x01 -> Sum=0x02.
REQ-035 With SERIAL_ADD_SUB_EN: A=0x10, B=0x01, Sub=1 -> Sum=0x0F, Cout=1; A=0x01, B=0x02, Sub=1 -> Sum=0xFF, Cout=0.
